pet_needs_fsm: RTL and testbench

Parametrised needs-and-mood control unit for the virtual pet. It keeps three saturating need levels (energy, food, fun) that decay on a prescaled game tick, applies the player actions (sleep, awake, feed, play, gyro shake) and resolves a prioritised mood state for the display and sound blocks. It replaces the fixed-width sleep/test controller with configurable level width, decay rates, death timeout and a per-need test-load port.

---
 rtl/pet_needs_fsm.sv | 254 +++++++++++++++++++++++++
 tb/tb_pet_needs_fsm.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pet_needs_fsm.sv
// Needs-and-mood controller for the virtual pet: three saturating need levels
// decaying on a prescaled game tick, player actions, and a registered mood code.
module pet_needs_fsm #(
  parameter int LEVEL_W     = 3,
  parameter int INIT_LEVEL  = 5,
  parameter int TICK_DIV    = 5,
  parameter int E_DECAY     = 4,
  parameter int F_DECAY     = 4,
  parameter int P_DECAY     = 4,
  parameter int DEATH_TICKS = 20,
  parameter int SLEEP_GAIN  = 2,
  parameter int FEED_STEP   = 2,
  parameter int PLAY_TICKS  = 8,
  parameter int LOW_TH      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_sleep,
  input  logic               btn_awake,
  input  logic               btn_feed,
  input  logic               btn_play,
  input  logic               giro,
  input  logic               btn_test,
  input  logic [1:0]         test_sel,
  input  logic [LEVEL_W-1:0] test_value,
  output logic [LEVEL_W-1:0] energy,
  output logic [LEVEL_W-1:0] food,
  output logic [LEVEL_W-1:0] fun,
  output logic [3:0]         state,
  output logic               sign_IDLE,
  output logic               sign_SLEEP,
  output logic               sign_NEUTRAL,
  output logic               sign_TIRED,
  output logic               sign_DEATH,
  output logic               sign_HUNGRY,
  output logic               sign_SAD,
  output logic               sign_PLAYING,
  output logic               sign_BORED
);
  // state   | meaning
  // IDLE    | after reset, until the first game tick
  // SLEEP   | asleep, energy recovering
  // NEUTRAL | no need is low
  // TIRED   | energy low
  // DEATH   | exhausted and starved, absorbing until reset
  // HUNGRY  | food low
  // SAD     | two or more needs low
  // PLAYING | play session running
  // BORED   | fun low
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_SLEEP   = 4'd1;
  localparam logic [3:0] S_NEUTRAL = 4'd2;
  localparam logic [3:0] S_TIRED   = 4'd3;
  localparam logic [3:0] S_DEATH   = 4'd4;
  localparam logic [3:0] S_HUNGRY  = 4'd5;
  localparam logic [3:0] S_SAD     = 4'd6;
  localparam logic [3:0] S_PLAYING = 4'd7;
  localparam logic [3:0] S_BORED   = 4'd8;

  localparam int CW = 16;
  localparam int SW = LEVEL_W + 2;
  localparam logic [CW-1:0]      C1     = CW'(1);
  localparam logic [LEVEL_W-1:0] MAX_L  = '1;
  localparam logic [SW-1:0]      MAX_S  = {2'b00, MAX_L};
  localparam logic [SW-1:0]      ONE_S  = SW'(1);
  localparam logic [SW-1:0]      FEED_S = SW'(FEED_STEP);
  localparam logic [LEVEL_W-1:0] LOW_L  = LEVEL_W'(LOW_TH);
  localparam logic [LEVEL_W-1:0] INIT_L = LEVEL_W'(INIT_LEVEL);

  logic sleep_q, awake_q, feed_q, play_q, giro_q, test_q;
  logic r_sleep, r_awake, r_feed, r_play, r_giro, r_test;
  logic tick, live, ld, ld_e, ld_f, ld_p;
  logic e_dec, e_inc, f_dec, p_dec;
  logic [SW-1:0] e_add, feed_add, giro_add;
  logic [CW-1:0] pre_cnt, e_cnt, s_cnt, f_cnt, p_cnt, d_cnt, play_cnt;
  logic asleep, playing, dead, started;
  logic e_low, f_low, p_low;
  logic [1:0] low_cnt;
  logic [3:0] mood;
  logic [8:0] signs;

  // Decrement (floored at 0) then add, saturating at MAX: covers decay+feed in one cycle.
  function automatic logic [LEVEL_W-1:0] sat_step(input logic [LEVEL_W-1:0] lvl,
                                                  input logic dec,
                                                  input logic [SW-1:0] add);
    logic [SW-1:0] sum;
    sum = {2'b00, lvl};
    if (dec && lvl != '0) sum = sum - ONE_S;
    sum = sum + add;
    if (sum > MAX_S) sum = MAX_S;
    return sum[LEVEL_W-1:0];
  endfunction

  assign r_sleep = btn_sleep & ~sleep_q;
  assign r_awake = btn_awake & ~awake_q;
  assign r_feed  = btn_feed  & ~feed_q;
  assign r_play  = btn_play  & ~play_q;
  assign r_giro  = giro      & ~giro_q;
  assign r_test  = btn_test  & ~test_q;

  assign tick = (pre_cnt == CW'(TICK_DIV - 1));
  assign live = ~dead;
  assign ld   = r_test & live;
  assign ld_e = ld & ((test_sel == 2'd0) | (test_sel == 2'd3));
  assign ld_f = ld & ((test_sel == 2'd1) | (test_sel == 2'd3));
  assign ld_p = ld & ((test_sel == 2'd2) | (test_sel == 2'd3));

  assign e_dec = tick & ~asleep & (e_cnt == CW'(E_DECAY - 1));
  assign e_inc = tick &  asleep & (s_cnt == CW'(SLEEP_GAIN - 1));
  assign f_dec = tick & (f_cnt == CW'(F_DECAY - 1));
  assign p_dec = tick & (p_cnt == CW'(P_DECAY - 1));

  assign e_add    = e_inc ? ONE_S : '0;
  assign feed_add = r_feed ? FEED_S : '0;
  assign giro_add = (r_giro & playing) ? ONE_S : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {sleep_q, awake_q, feed_q, play_q, giro_q, test_q} <= '0;
      pre_cnt <= '0;
    end else begin
      {sleep_q, awake_q, feed_q, play_q, giro_q, test_q} <=
        {btn_sleep, btn_awake, btn_feed, btn_play, giro, btn_test};
      pre_cnt <= tick ? '0 : pre_cnt + C1;
    end
  end

  // Energy decay counter holds its phase while asleep; the gain counter runs instead.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      energy <= INIT_L;
      e_cnt  <= '0;
      s_cnt  <= '0;
    end else if (ld_e) begin
      energy <= test_value;
      e_cnt  <= '0;
      s_cnt  <= '0;
    end else if (live) begin
      energy <= sat_step(energy, e_dec, e_add);
      if (asleep) begin
        if (tick) s_cnt <= e_inc ? '0 : s_cnt + C1;
      end else begin
        s_cnt <= '0;
        if (tick) e_cnt <= e_dec ? '0 : e_cnt + C1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      food  <= INIT_L;
      f_cnt <= '0;
    end else if (ld_f) begin
      food  <= test_value;
      f_cnt <= '0;
    end else if (live) begin
      food <= sat_step(food, f_dec, feed_add);
      if (tick) f_cnt <= f_dec ? '0 : f_cnt + C1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fun   <= INIT_L;
      p_cnt <= '0;
    end else if (ld_p) begin
      fun   <= test_value;
      p_cnt <= '0;
    end else if (live) begin
      fun <= sat_step(fun, p_dec, giro_add);
      if (tick) p_cnt <= p_dec ? '0 : p_cnt + C1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_cnt <= '0;
      dead  <= 1'b0;
    end else if (live) begin
      if (energy == '0 && food == '0) begin
        if (tick) begin
          if (d_cnt == CW'(DEATH_TICKS - 1)) dead <= 1'b1;
          d_cnt <= d_cnt + C1;
        end
      end else begin
        d_cnt <= '0;
      end
    end
  end

  // Awake beats sleep on coincident edges; a full battery ends sleep by itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asleep   <= 1'b0;
      playing  <= 1'b0;
      play_cnt <= '0;
    end else if (live) begin
      if (r_awake)                      asleep <= 1'b0;
      else if (r_sleep && !playing)     asleep <= 1'b1;
      else if (asleep && energy == MAX_L) asleep <= 1'b0;

      if (playing) begin
        if (r_play || energy == '0 || (tick && play_cnt == CW'(PLAY_TICKS - 1)))
          playing <= 1'b0;
        else if (tick)
          play_cnt <= play_cnt + C1;
      end else if (r_play && !asleep && energy != '0) begin
        playing  <= 1'b1;
        play_cnt <= '0;
      end
    end
  end

  assign e_low   = (energy <= LOW_L);
  assign f_low   = (food   <= LOW_L);
  assign p_low   = (fun    <= LOW_L);
  assign low_cnt = {1'b0, e_low} + {1'b0, f_low} + {1'b0, p_low};

  always_comb begin
    mood = S_NEUTRAL;
    if (dead)                 mood = S_DEATH;
    else if (asleep)          mood = S_SLEEP;
    else if (playing)         mood = S_PLAYING;
    else if (low_cnt >= 2'd2) mood = S_SAD;
    else if (f_low)           mood = S_HUNGRY;
    else if (e_low)           mood = S_TIRED;
    else if (p_low)           mood = S_BORED;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      signs   <= 9'd1;
      started <= 1'b0;
    end else begin
      if (tick) started <= 1'b1;
      if (tick || started) begin
        state <= mood;
        signs <= 9'd1 << mood;
      end
    end
  end

  assign sign_IDLE    = signs[0];
  assign sign_SLEEP   = signs[1];
  assign sign_NEUTRAL = signs[2];
  assign sign_TIRED   = signs[3];
  assign sign_DEATH   = signs[4];
  assign sign_HUNGRY  = signs[5];
  assign sign_SAD     = signs[6];
  assign sign_PLAYING = signs[7];
  assign sign_BORED   = signs[8];

endmodule

// File: tb/tb_pet_needs_fsm.sv
// Bench for pet_needs_fsm: directed scenarios with fixed expectations plus a
// randomized run compared against a rule-level reference model.
module tb_pet_needs_fsm;
  localparam int LEVEL_W = 3, INIT_LEVEL = 5, TICK_DIV = 5, E_DECAY = 4, F_DECAY = 4, P_DECAY = 4;
  localparam int DEATH_TICKS = 20, SLEEP_GAIN = 2, FEED_STEP = 2, PLAY_TICKS = 8, LOW_TH = 1;
  localparam int MAXV = (1 << LEVEL_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_sleep = 0, btn_awake = 0, btn_feed = 0, btn_play = 0, giro = 0, btn_test = 0;
  logic [1:0] test_sel = '0;
  logic [LEVEL_W-1:0] test_value = '0;
  logic [LEVEL_W-1:0] energy, food, fun;
  logic [3:0] state;
  logic sign_IDLE, sign_SLEEP, sign_NEUTRAL, sign_TIRED, sign_DEATH;
  logic sign_HUNGRY, sign_SAD, sign_PLAYING, sign_BORED;
  logic [8:0] signs_v;
  int errors = 0;
  int checks = 0;

  pet_needs_fsm dut (
    .clk(clk), .rst(rst), .btn_sleep(btn_sleep), .btn_awake(btn_awake), .btn_feed(btn_feed),
    .btn_play(btn_play), .giro(giro), .btn_test(btn_test), .test_sel(test_sel),
    .test_value(test_value), .energy(energy), .food(food), .fun(fun), .state(state),
    .sign_IDLE(sign_IDLE), .sign_SLEEP(sign_SLEEP), .sign_NEUTRAL(sign_NEUTRAL),
    .sign_TIRED(sign_TIRED), .sign_DEATH(sign_DEATH), .sign_HUNGRY(sign_HUNGRY),
    .sign_SAD(sign_SAD), .sign_PLAYING(sign_PLAYING), .sign_BORED(sign_BORED)
  );

  assign signs_v = {sign_BORED, sign_PLAYING, sign_SAD, sign_HUNGRY, sign_DEATH,
                    sign_TIRED, sign_NEUTRAL, sign_SLEEP, sign_IDLE};

  always #5 clk = ~clk;

  // Reference model: plain integers, tick counts and the mood priority list.
  int m_e, m_f, m_p, m_st, m_cyc, m_ec, m_fc, m_pc, m_sc, m_dc, m_plc;
  bit m_asleep, m_play, m_dead, m_started;
  bit pv_sleep, pv_awake, pv_feed, pv_play, pv_giro, pv_test;

  function automatic int mood_of(bit d, bit a, bit pl, int e, int f, int p);
    int lows;
    lows = int'(e <= LOW_TH) + int'(f <= LOW_TH) + int'(p <= LOW_TH);
    if (d) return 4;
    if (a) return 1;
    if (pl) return 7;
    if (lows >= 2) return 6;
    if (f <= LOW_TH) return 5;
    if (e <= LOW_TH) return 3;
    if (p <= LOW_TH) return 8;
    return 2;
  endfunction

  always @(posedge clk or negedge rst) begin
    bit tk, rs, ra, rf, rp, rg, rt, a0, pl0, fd, pd;
    int e0, f0, p0;
    if (!rst) begin
      m_e = INIT_LEVEL; m_f = INIT_LEVEL; m_p = INIT_LEVEL; m_st = 0; m_cyc = 0;
      m_ec = 0; m_fc = 0; m_pc = 0; m_sc = 0; m_dc = 0; m_plc = 0;
      m_asleep = 0; m_play = 0; m_dead = 0; m_started = 0;
      {pv_sleep, pv_awake, pv_feed, pv_play, pv_giro, pv_test} = '0;
    end else begin
      rs = btn_sleep & !pv_sleep; ra = btn_awake & !pv_awake; rf = btn_feed & !pv_feed;
      rp = btn_play & !pv_play;   rg = giro & !pv_giro;       rt = btn_test & !pv_test;
      m_cyc++;
      tk = (m_cyc % TICK_DIV) == 0;
      e0 = m_e; f0 = m_f; p0 = m_p; a0 = m_asleep; pl0 = m_play;
      if (m_started || tk) m_st = mood_of(m_dead, a0, pl0, e0, f0, p0);
      if (tk) m_started = 1;
      if (!m_dead) begin
        if (rt && (test_sel == 0 || test_sel == 3)) begin
          m_e = test_value; m_ec = 0; m_sc = 0;
        end else if (a0) begin
          if (tk) begin
            m_sc++;
            if (m_sc == SLEEP_GAIN) begin m_sc = 0; m_e = (e0 + 1 > MAXV) ? MAXV : e0 + 1; end
          end
        end else begin
          m_sc = 0;
          if (tk) begin
            m_ec++;
            if (m_ec == E_DECAY) begin m_ec = 0; m_e = (e0 > 0) ? e0 - 1 : 0; end
          end
        end
        if (rt && (test_sel == 1 || test_sel == 3)) begin
          m_f = test_value; m_fc = 0;
        end else begin
          fd = 0;
          if (tk) begin m_fc++; if (m_fc == F_DECAY) begin m_fc = 0; fd = 1; end end
          m_f = ((f0 > 0 && fd) ? f0 - 1 : f0) + (rf ? FEED_STEP : 0);
          if (m_f > MAXV) m_f = MAXV;
        end
        if (rt && (test_sel == 2 || test_sel == 3)) begin
          m_p = test_value; m_pc = 0;
        end else begin
          pd = 0;
          if (tk) begin m_pc++; if (m_pc == P_DECAY) begin m_pc = 0; pd = 1; end end
          m_p = ((p0 > 0 && pd) ? p0 - 1 : p0) + ((rg && pl0) ? 1 : 0);
          if (m_p > MAXV) m_p = MAXV;
        end
        if (e0 == 0 && f0 == 0) begin
          if (tk) begin m_dc++; if (m_dc == DEATH_TICKS) m_dead = 1; end
        end else m_dc = 0;
        if (ra) m_asleep = 0;
        else if (rs && !pl0) m_asleep = 1;
        else if (a0 && e0 == MAXV) m_asleep = 0;
        if (pl0) begin
          if (tk) m_plc++;
          if (rp || e0 == 0 || m_plc == PLAY_TICKS) m_play = 0;
        end else if (rp && !a0 && e0 > 0) begin
          m_play = 1; m_plc = 0;
        end
      end
      {pv_sleep, pv_awake, pv_feed, pv_play, pv_giro, pv_test} =
        {btn_sleep, btn_awake, btn_feed, btn_play, giro, btn_test};
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    {btn_sleep, btn_awake, btn_feed, btn_play, giro, btn_test} = '0;
    test_sel = '0; test_value = '0;
    cyc(2);
    rst = 1'b1;
  endtask

  // Two cycles per press: action on the first edge, mood visible after the second.
  task automatic press(input int which);
    case (which)
      0: btn_sleep = 1; 1: btn_awake = 1; 2: btn_feed = 1; 3: btn_play = 1;
      4: giro = 1;      default: btn_test = 1;
    endcase
    cyc(1);
    {btn_sleep, btn_awake, btn_feed, btn_play, giro, btn_test} = '0;
    cyc(1);
  endtask

  task automatic load(input int sel, input int val);
    test_sel = 2'(sel); test_value = LEVEL_W'(val);
    press(5);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cyc(2);
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (signs_v !== 9'h001) begin errors++; $display("FAIL reset_signs: got %h want 001", signs_v); end
    checks++; if ({energy, food, fun} !== {3'd5, 3'd5, 3'd5}) begin
      errors++; $display("FAIL reset_levels: got %0d/%0d/%0d want 5/5/5", energy, food, fun); end
    rst = 1'b1;
  endtask

  task automatic test_decay();
    do_reset();
    cyc(4);
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL idle_hold: got %0d want 0", state); end
    cyc(1);
    checks++; if (state !== 4'd2) begin errors++; $display("FAIL first_tick_neutral: got %0d want 2", state); end
    cyc(14);
    checks++; if (energy !== 3'd5) begin errors++; $display("FAIL decay_pre20: got %0d want 5", energy); end
    cyc(1);
    checks++; if ({energy, food, fun} !== {3'd4, 3'd4, 3'd4}) begin
      errors++; $display("FAIL decay_at20: got %0d/%0d/%0d want 4/4/4", energy, food, fun); end
    cyc(20);
    checks++; if (energy !== 3'd3) begin errors++; $display("FAIL decay_at40: got %0d want 3", energy); end
  endtask

  task automatic test_death();
    do_reset();
    cyc(7);
    load(3, 0);
    checks++; if ({energy, food, fun} !== 9'd0) begin
      errors++; $display("FAIL death_load: got %0d/%0d/%0d want 0/0/0", energy, food, fun); end
    checks++; if (state !== 4'd6) begin errors++; $display("FAIL death_sad: got %0d want 6", state); end
    cyc(96);
    checks++; if (state !== 4'd6) begin errors++; $display("FAIL death_tick19: got %0d want 6", state); end
    cyc(1);
    checks++; if (state !== 4'd4 || signs_v !== 9'h010) begin
      errors++; $display("FAIL death_enter: got %0d/%h want 4/010", state, signs_v); end
    press(2);
    load(0, 7);
    checks++; if (energy !== 3'd0 || food !== 3'd0 || state !== 4'd4) begin
      errors++; $display("FAIL death_absorb: got e=%0d f=%0d st=%0d want 0 0 4", energy, food, state); end
    rst = 1'b0;
    #2;
    checks++; if ({energy, food, fun} !== {3'd5, 3'd5, 3'd5} || state !== 4'd0 || signs_v !== 9'h001) begin
      errors++; $display("FAIL death_reset: got %0d/%0d/%0d st=%0d want 5/5/5 0", energy, food, fun, state); end
    cyc(1);
    rst = 1'b1;
  endtask

  task automatic test_feed();
    do_reset();
    cyc(7);
    load(1, 6);
    checks++; if (food !== 3'd6) begin errors++; $display("FAIL feed_load: got %0d want 6", food); end
    press(2);
    checks++; if (food !== 3'd7) begin errors++; $display("FAIL feed_saturate: got %0d want 7", food); end
    cyc(13);
    checks++; if (food !== 3'd7) begin errors++; $display("FAIL feed_pre_decay: got %0d want 7", food); end
    cyc(1);
    checks++; if (food !== 3'd6) begin errors++; $display("FAIL feed_decay: got %0d want 6", food); end
    load(1, 5);
    cyc(17);
    checks++; if (food !== 3'd5) begin errors++; $display("FAIL feed_before_coinc: got %0d want 5", food); end
    btn_feed = 1;
    cyc(1);
    checks++; if (food !== 3'd6) begin errors++; $display("FAIL feed_coincident: got %0d want 6", food); end
    btn_feed = 0;
    cyc(1);
  endtask

  task automatic test_hold();
    do_reset();
    cyc(7);
    load(1, 1);
    btn_feed = 1;
    cyc(4);
    checks++; if (food !== 3'd3) begin errors++; $display("FAIL hold_one_action: got %0d want 3", food); end
    btn_feed = 0;
    cyc(1);
  endtask

  task automatic test_sleep();
    do_reset();
    cyc(7);
    load(0, 2);
    press(0);
    checks++; if (state !== 4'd1 || sign_SLEEP !== 1'b1) begin
      errors++; $display("FAIL sleep_enter: got %0d want 1", state); end
    cyc(8);
    checks++; if (energy !== 3'd2) begin errors++; $display("FAIL sleep_pre_gain: got %0d want 2", energy); end
    cyc(1);
    checks++; if (energy !== 3'd3) begin errors++; $display("FAIL sleep_gain: got %0d want 3", energy); end
    cyc(40);
    checks++; if (energy !== 3'd7) begin errors++; $display("FAIL sleep_full: got %0d want 7", energy); end
    cyc(1);
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL sleep_last: got %0d want 1", state); end
    cyc(1);
    checks++; if (state !== 4'd2) begin errors++; $display("FAIL sleep_autowake: got %0d want 2", state); end
    load(0, 2);
    press(0);
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL sleep_again: got %0d want 1", state); end
    press(1);
    checks++; if (state !== 4'd2) begin errors++; $display("FAIL sleep_awake_exit: got %0d want 2", state); end
  endtask

  task automatic test_play();
    do_reset();
    cyc(7);
    load(2, 1);
    press(3);
    checks++; if (state !== 4'd7 || sign_PLAYING !== 1'b1) begin
      errors++; $display("FAIL play_enter: got %0d want 7", state); end
    press(4); press(4); press(4);
    checks++; if (fun !== 3'd4) begin errors++; $display("FAIL play_giro: got %0d want 4", fun); end
    cyc(33);
    checks++; if (state !== 4'd7) begin errors++; $display("FAIL play_last_tick: got %0d want 7", state); end
    cyc(1);
    checks++; if (state !== 4'd2) begin errors++; $display("FAIL play_timeout: got %0d want 2", state); end
    load(0, 0);
    press(3);
    checks++; if (state !== 4'd3 || sign_PLAYING !== 1'b0) begin
      errors++; $display("FAIL play_reject_e0: got %0d want 3", state); end
  endtask

  task automatic test_moods();
    do_reset();
    cyc(7);
    load(2, 1);
    load(1, 1);
    checks++; if (state !== 4'd6) begin errors++; $display("FAIL mood_sad: got %0d want 6", state); end
    load(2, 5);
    checks++; if (state !== 4'd5) begin errors++; $display("FAIL mood_hungry: got %0d want 5", state); end
    load(1, 5);
    checks++; if (state !== 4'd2) begin errors++; $display("FAIL mood_neutral: got %0d want 2", state); end
    load(0, 1);
    checks++; if (state !== 4'd3) begin errors++; $display("FAIL mood_tired: got %0d want 3", state); end
    load(0, 5);
    load(2, 0);
    checks++; if (state !== 4'd8 || signs_v !== 9'h100) begin
      errors++; $display("FAIL mood_bored: got %0d/%h want 8/100", state, signs_v); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      checks++; if (energy !== LEVEL_W'(m_e)) begin errors++; $display("FAIL rnd_energy @%0d: got %0d want %0d", i, energy, m_e); end
      checks++; if (food !== LEVEL_W'(m_f)) begin errors++; $display("FAIL rnd_food @%0d: got %0d want %0d", i, food, m_f); end
      checks++; if (fun !== LEVEL_W'(m_p)) begin errors++; $display("FAIL rnd_fun @%0d: got %0d want %0d", i, fun, m_p); end
      checks++; if (state !== 4'(m_st)) begin errors++; $display("FAIL rnd_state @%0d: got %0d want %0d", i, state, m_st); end
      checks++; if (signs_v !== (9'd1 << m_st)) begin errors++; $display("FAIL rnd_signs @%0d: got %h want state %0d", i, signs_v, m_st); end
      rst = (i % 700 == 699) ? 1'b0 : 1'b1;
      btn_sleep  = ($urandom_range(0, 5) == 0);
      btn_awake  = ($urandom_range(0, 9) == 0);
      btn_feed   = ($urandom_range(0, 7) == 0);
      btn_play   = ($urandom_range(0, 5) == 0);
      giro       = ($urandom_range(0, 2) == 0);
      btn_test   = ($urandom_range(0, 24) == 0);
      test_sel   = 2'($urandom_range(0, 3));
      test_value = LEVEL_W'($urandom_range(0, MAXV));
    end
  endtask

  initial begin
    test_reset();
    test_decay();
    test_death();
    test_feed();
    test_hold();
    test_sleep();
    test_play();
    test_moods();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
